// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for RISC-V loads (LB/LH/LW/LBU/LHU) and stores
//   (SB/SH/SW) against an internal word array. It behaves as a slow memory
//   with WAIT_CYCLES wait states and holds stall high until the access is
//   answered with a one-cycle ack.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (the memory array is not reset)
//   mem_read_en   load request, held stable while stall=1
//   mem_write_en  store request, held stable while stall=1
//   funct3        access size/sign (instruction[14:12])
//   addr          byte address; bits above the word index are ignored
//   wdata         store data; the low bytes are used for SB/SH
//   rdata         extended load data, non-zero only in the ack cycle
//   ack           one-cycle completion pulse
//   stall         freeze request to the PC/regfile
//   access_err    misaligned/illegal access flag, valid in the ack cycle
//
// state  | meaning
// S_IDLE | no access in flight; a request starts the wait-state timer
// S_WAIT | wait-state countdown; the request must stay asserted
// S_RESP | ack cycle; a store commits on the edge that leaves this state
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        stall,
   output logic        access_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   // The cycle spent in S_IDLE already counts as one stall cycle, so the
   // timer starts at WAIT_CYCLES-1. Total stall is then WAIT_CYCLES+1 cycles.
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;

   logic [31:0] mem [DEPTH_WORDS];

   logic             req;
   logic [IDX_W-1:0] idx;
   logic [1:0]       lane;
   logic [31:0]      word_rd;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic             err_now;
   logic [31:0]      load_val;
   logic [3:0]       be;
   logic [31:0]      wdata_lane;
   logic             load_rdata;
   logic             do_write;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             addr_unused;

   assign req         = mem_read_en | mem_write_en;
   assign idx         = addr[IDX_W+1:2];
   assign lane        = addr[1:0];
   assign addr_unused = ^addr[31:IDX_W+2];
   assign word_rd     = mem[idx];
   assign ld_byte     = word_rd[{lane, 3'b000} +: 8];
   assign ld_half     = addr[1] ? word_rd[31:16] : word_rd[15:0];
   assign stall       = req & (state != S_RESP);

   // Access decode: legality, load extension and store byte enables.
   always_comb begin
      err_now    = 1'b0;
      load_val   = 32'd0;
      be         = 4'b0000;
      wdata_lane = wdata;
      if (mem_read_en && mem_write_en) begin
         err_now = 1'b1;
      end else if (mem_read_en) begin
         case (funct3)
            3'b000: load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001: begin
               if (addr[0]) err_now = 1'b1;
               else         load_val = {{16{ld_half[15]}}, ld_half};
            end
            3'b010: begin
               if (lane != 2'b00) err_now = 1'b1;
               else               load_val = word_rd;
            end
            3'b100: load_val = {24'd0, ld_byte};
            3'b101: begin
               if (addr[0]) err_now = 1'b1;
               else         load_val = {16'd0, ld_half};
            end
            default: err_now = 1'b1;
         endcase
      end else if (mem_write_en) begin
         case (funct3)
            3'b000: begin
               be         = 4'b0001 << lane;
               wdata_lane = {4{wdata[7:0]}};
            end
            3'b001: begin
               if (addr[0]) begin
                  err_now = 1'b1;
               end else begin
                  be         = addr[1] ? 4'b1100 : 4'b0011;
                  wdata_lane = {2{wdata[15:0]}};
               end
            end
            3'b010: begin
               if (lane != 2'b00) err_now = 1'b1;
               else               be = 4'b1111;
            end
            default: err_now = 1'b1;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      load_rdata = 1'b0;
      do_write   = 1'b0;
      ack        = 1'b0;
      access_err = 1'b0;
      rdata      = 32'd0;
      case (state)
         S_IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = S_RESP;
                  load_rdata = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt  = S_RESP;
               load_rdata = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
            // A request dropped by the time we reach RESP is a flush.
            if (req) begin
               ack        = 1'b1;
               access_err = err_q;
               rdata      = rdata_q;
               do_write   = mem_write_en & ~err_q;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (load_rdata) begin
            err_q   <= err_now;
            rdata_q <= err_now ? 32'd0 : load_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mre   [2];
   logic        mwe   [2];
   logic [2:0]  f3    [2];
   logic [31:0] ad    [2];
   logic [31:0] wd    [2];
   logic [31:0] rd_o  [2];
   logic        ack_o [2];
   logic        stl_o [2];
   logic        err_o [2];

   int errors = 0;
   int checks = 0;

   // Reference memory image per instance (index 0: WAIT_CYCLES=2, 1: WAIT_CYCLES=0).
   logic [31:0] mm [2][1024];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read_en(mre[0]), .mem_write_en(mwe[0]), .funct3(f3[0]),
      .addr(ad[0]), .wdata(wd[0]),
      .rdata(rd_o[0]), .ack(ack_o[0]), .stall(stl_o[0]), .access_err(err_o[0])
   );

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .mem_read_en(mre[1]), .mem_write_en(mwe[1]), .funct3(f3[1]),
      .addr(ad[1]), .wdata(wd[1]),
      .rdata(rd_o[1]), .ack(ack_o[1]), .stall(stl_o[1]), .access_err(err_o[1])
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic model_err(input logic r, input logic w,
                                      input logic [2:0] f, input logic [31:0] a);
      int off = int'(a % 4);
      if (r && w) return 1'b1;
      if (r) begin
         if (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      end else begin
         if (!(f inside {3'd0, 3'd1, 3'd2})) return 1'b1;
      end
      if ((f == 3'd1 || (r && f == 3'd5)) && (off % 2 != 0)) return 1'b1;
      if (f == 3'd2 && off != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input int s, input logic [2:0] f,
                                              input logic [31:0] a);
      logic [31:0] w = mm[s][(a / 4) % 1024];
      int          off = int'(a % 4);
      logic [7:0]  b = 8'(w >> (8 * off));
      logic [15:0] h = 16'(w >> (16 * (off / 2)));
      case (f)
         3'd0:    return int'($signed(b));
         3'd1:    return int'($signed(h));
         3'd2:    return w;
         3'd4:    return {24'd0, b};
         default: return {16'd0, h};
      endcase
   endfunction

   task automatic model_store(input int s, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] d);
      int i   = int'((a / 4) % 1024);
      int off = int'(a % 4);
      case (f)
         3'd0:    mm[s][i][8*off +: 8]        = d[7:0];
         3'd1:    mm[s][i][16*(off/2) +: 16]  = d[15:0];
         default: mm[s][i]                    = d;
      endcase
   endtask

   // Drives one access, holds it until the ack cycle plus the committing
   // edge, and reports what was seen. Timeout shows up as got_ack=0.
   task automatic run_op(input int s, input logic r, input logic w,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output logic got_ack,
                         output logic got_err, output logic [31:0] got_rd);
      @(negedge clk);
      mre[s] = r; mwe[s] = w; f3[s] = f; ad[s] = a; wd[s] = d;
      stalls = 0; got_ack = 1'b0; got_err = 1'b0; got_rd = 32'd0;
      for (int i = 0; i < 40 && !got_ack; i++) begin
         #1;
         if (ack_o[s]) begin
            got_ack = 1'b1;
            got_err = err_o[s];
            got_rd  = rd_o[s];
         end else begin
            if (stl_o[s]) stalls++;
            @(negedge clk);
         end
      end
      @(posedge clk);
      #1;
      mre[s] = 1'b0; mwe[s] = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         mre[s] = 0; mwe[s] = 0; f3[s] = 0; ad[s] = 0; wd[s] = 0;
      end
      #12;
      checks++; if (ack_o[0] !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b exp 0", ack_o[0]); end
      checks++; if (stl_o[0] !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stl_o[0]); end
      checks++; if (rd_o[0] !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rd_o[0]); end
      checks++; if (err_o[0] !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_o[0]); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int st; logic k, e; logic [31:0] v;
      run_op(0, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, st, k, e, v);
      model_store(0, 3'd2, 32'h10, 32'hDEADBEEF);
      checks++; if (st != 3) begin errors++; $display("FAIL sw_stall_cycles: got %0d exp 3", st); end
      checks++; if (k !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL sw_ack: got ack=%b err=%b exp ack=1 err=0", k, e); end
      @(negedge clk); #1;
      checks++; if (ack_o[0] !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b exp 0", ack_o[0]); end
      run_op(0, 1, 0, 3'd2, 32'h10, 32'h0, st, k, e, v);
      checks++; if (v !== 32'hDEADBEEF || k !== 1'b1) begin errors++; $display("FAIL lw_basic: got %h ack=%b exp deadbeef", v, k); end
      checks++; if (st != 3) begin errors++; $display("FAIL lw_stall_cycles: got %0d exp 3", st); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  tf [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
      logic [31:0] ta [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] te [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
      int st; logic k, e; logic [31:0] v;
      for (int i = 0; i < 4; i++) begin
         run_op(0, 1, 0, tf[i], ta[i], 32'h0, st, k, e, v);
         checks++;
         if (v !== te[i] || e !== 1'b0 || k !== 1'b1)
            begin errors++; $display("FAIL load_ext_%0d: got %h err=%b exp %h", i, v, e, te[i]); end
      end
   endtask

   task automatic test_partial_store();
      int st; logic k, e; logic [31:0] v;
      run_op(0, 0, 1, 3'd0, 32'h11, 32'h000000AA, st, k, e, v);
      model_store(0, 3'd0, 32'h11, 32'h000000AA);
      run_op(0, 1, 0, 3'd2, 32'h10, 32'h0, st, k, e, v);
      checks++; if (v !== 32'hDEADAAEF) begin errors++; $display("FAIL sb_lane: got %h exp deadaaef", v); end
      run_op(0, 0, 1, 3'd1, 32'h12, 32'h00001234, st, k, e, v);
      model_store(0, 3'd1, 32'h12, 32'h00001234);
      run_op(0, 1, 0, 3'd2, 32'h10, 32'h0, st, k, e, v);
      checks++; if (v !== 32'h1234AAEF) begin errors++; $display("FAIL sh_half: got %h exp 1234aaef", v); end
   endtask

   task automatic test_errors();
      int st; logic k, e; logic [31:0] v;
      run_op(0, 1, 0, 3'd2, 32'h02, 32'h0, st, k, e, v);
      checks++; if (e !== 1'b1 || v !== 32'd0 || k !== 1'b1) begin errors++; $display("FAIL lw_misaligned: got err=%b rdata=%h exp err=1 rdata=0", e, v); end
      run_op(0, 0, 1, 3'd1, 32'h11, 32'hFFFFFFFF, st, k, e, v);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL sh_misaligned: got err=%b exp 1", e); end
      run_op(0, 1, 1, 3'd2, 32'h10, 32'h55555555, st, k, e, v);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL both_enables: got err=%b exp 1", e); end
      run_op(0, 1, 0, 3'd3, 32'h10, 32'h0, st, k, e, v);
      checks++; if (e !== 1'b1 || v !== 32'd0) begin errors++; $display("FAIL bad_load_f3: got err=%b rdata=%h exp err=1 rdata=0", e, v); end
      run_op(0, 0, 1, 3'd4, 32'h10, 32'h66666666, st, k, e, v);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_store_f3: got err=%b exp 1", e); end
      run_op(0, 1, 0, 3'd2, 32'h10, 32'h0, st, k, e, v);
      checks++; if (v !== 32'h1234AAEF) begin errors++; $display("FAIL err_no_write: got %h exp 1234aaef", v); end
   endtask

   task automatic test_flush();
      int st; int seen; logic k, e; logic [31:0] v;
      run_op(0, 0, 1, 3'd2, 32'h20, 32'h11112222, st, k, e, v);
      model_store(0, 3'd2, 32'h20, 32'h11112222);
      @(negedge clk);
      mwe[0] = 1; f3[0] = 3'd2; ad[0] = 32'h20; wd[0] = 32'h99999999;
      @(negedge clk); #1;
      checks++; if (stl_o[0] !== 1'b1) begin errors++; $display("FAIL flush_in_wait: got stall=%b exp 1", stl_o[0]); end
      mwe[0] = 0;
      #1;
      checks++; if (stl_o[0] !== 1'b0) begin errors++; $display("FAIL flush_stall_drop: got %b exp 0", stl_o[0]); end
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (ack_o[0]) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_ack: got %0d acks exp 0", seen); end
      run_op(0, 1, 0, 3'd2, 32'h20, 32'h0, st, k, e, v);
      checks++; if (v !== 32'h11112222 || st != 3) begin errors++; $display("FAIL flush_no_write: got %h stalls=%0d exp 11112222 stalls=3", v, st); end
   endtask

   task automatic test_reset_mid();
      int st; logic k, e; logic [31:0] v;
      run_op(0, 0, 1, 3'd2, 32'h24, 32'hCAFEF00D, st, k, e, v);
      model_store(0, 3'd2, 32'h24, 32'hCAFEF00D);
      @(negedge clk);
      mwe[0] = 1; f3[0] = 3'd2; ad[0] = 32'h24; wd[0] = 32'h0BADBEEF;
      @(negedge clk); #2;
      rst_n = 0; mwe[0] = 0;
      #1;
      checks++; if (stl_o[0] !== 1'b0 || ack_o[0] !== 1'b0 || rd_o[0] !== 32'd0)
         begin errors++; $display("FAIL reset_mid_wait: got stall=%b ack=%b rdata=%h exp 0", stl_o[0], ack_o[0], rd_o[0]); end
      @(negedge clk); @(negedge clk); rst_n = 1;
      run_op(0, 1, 0, 3'd2, 32'h24, 32'h0, st, k, e, v);
      checks++; if (v !== 32'hCAFEF00D) begin errors++; $display("FAIL reset_no_write: got %h exp cafef00d", v); end
      // Reset while the load is being acknowledged.
      @(negedge clk);
      mre[0] = 1; f3[0] = 3'd2; ad[0] = 32'h24;
      k = 0;
      for (int i = 0; i < 40 && !k; i++) begin
         #1;
         if (ack_o[0]) k = 1; else @(negedge clk);
      end
      checks++; if (k !== 1'b1 || rd_o[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL resp_before_reset: got ack=%b rdata=%h exp 1 cafef00d", k, rd_o[0]); end
      rst_n = 0;
      #1;
      checks++; if (ack_o[0] !== 1'b0 || rd_o[0] !== 32'd0 || err_o[0] !== 1'b0)
         begin errors++; $display("FAIL reset_in_resp: got ack=%b rdata=%h exp 0", ack_o[0], rd_o[0]); end
      mre[0] = 0;
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_zero_wait();
      int st; logic k, e; logic [31:0] v;
      run_op(1, 0, 1, 3'd2, 32'h0, 32'h5A5A1234, st, k, e, v);
      model_store(1, 3'd2, 32'h0, 32'h5A5A1234);
      checks++; if (st != 1 || k !== 1'b1) begin errors++; $display("FAIL zw_stall: got stalls=%0d ack=%b exp 1 1", st, k); end
      run_op(1, 1, 0, 3'd2, 32'h1000, 32'h0, st, k, e, v);
      checks++; if (v !== 32'h5A5A1234 || st != 1) begin errors++; $display("FAIL zw_alias: got %h stalls=%0d exp 5a5a1234 1", v, st); end
      run_op(1, 0, 1, 3'd0, 32'h1003, 32'h00000077, st, k, e, v);
      model_store(1, 3'd0, 32'h1003, 32'h00000077);
      run_op(1, 1, 0, 3'd2, 32'h0, 32'h0, st, k, e, v);
      checks++; if (v !== model_load(1, 3'd2, 32'h0)) begin errors++; $display("FAIL zw_alias_sb: got %h exp %h", v, model_load(1, 3'd2, 32'h0)); end
   endtask

   task automatic test_random();
      logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      int st; logic k, e; logic [31:0] v;
      logic r, w, xe; logic [2:0] f; logic [31:0] a, d, xv;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         a = 32'h100 + 32'(4 * i);
         run_op(0, 0, 1, 3'd2, a, d, st, k, e, v);
         model_store(0, 3'd2, a, d);
         checks++; if (k !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL rnd_init_%0d: got ack=%b err=%b exp 1 0", i, k, e); end
      end
      for (int i = 0; i < 80; i++) begin
         r = 1'($urandom % 2);
         w = !r;
         if ($urandom % 10 == 0) begin r = 1; w = 1; end
         f = ($urandom % 4 == 0) ? 3'($urandom % 8) : legal[$urandom % 5];
         a = 32'h100 + ($urandom % 64) + (($urandom % 16) << 12);
         d = $urandom;
         xe = model_err(r, w, f, a);
         xv = (r && !w && !xe) ? model_load(0, f, a) : 32'd0;
         run_op(0, r, w, f, a, d, st, k, e, v);
         if (w && !r && !xe) model_store(0, f, a, d);
         checks++;
         if (k !== 1'b1 || e !== xe || st != 3 || (r && !w && v !== xv))
            begin errors++; $display("FAIL rnd_%0d: r=%b w=%b f3=%0d addr=%h got ack=%b err=%b rdata=%h stalls=%0d exp err=%b rdata=%h stalls=3", i, r, w, f, a, k, e, v, st, xe, xv); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_load_ext();
      test_partial_store();
      test_errors();
      test_flush();
      test_reset_mid();
      test_zero_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
